adder_vector_sequencer: RTL and testbench
=========================================

Name: adder_vector_sequencer

Overview:
Self-checking stimulus controller for the 8-bit / 9-bit-result adder datapath. It holds a vector table of operand A, operand B and expected sum, loaded through a write port. On start it steps through the table, drives the adder operands, waits a settle time, compares the adder result to the expected value, and reports error count, first failing index and a pass flag. It replaces file-driven bench checking with a synthesizable sequencer usable in simulation and on FPGA.

Parameters:
DW, 8, adder operand width; result and expected width is DW+1
DEPTH, 32, number of vector table entries
AW, 5, table address width; must satisfy 2**AW >= DEPTH
SETTLE, 1, number of wait cycles between driving operands and compare; legal range 0..15

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous reset, active-high
ld_en  in  1  table write strobe
ld_addr  in  AW  table write index
ld_a  in  DW  operand A to store
ld_b  in  DW  operand B to store
ld_exp  in  DW+1  expected sum to store
num_vec  in  AW+1  number of vectors to run; sampled on start
start  in  1  single-cycle run request
add_a  out  DW  operand A to the adder
add_b  out  DW  operand B to the adder
add_y  in  DW+1  adder result
busy  out  1  run in progress
done  out  1  run complete; held until the next accepted start or reset
pass  out  1  done and err_cnt==0
err_cnt  out  AW+1  mismatch count for the current or last run
fail_idx  out  AW  index of the first mismatch
fail_vld  out  1  fail_idx is valid

Behaviour:
- Reset, synchronous and active-high, with clk as the single clock. Reset clears all outputs: add_a=0, add_b=0, busy=0, done=0, pass=0, err_cnt=0, fail_idx=0, fail_vld=0. The FSM goes to IDLE. Table contents are not reset.
- Table writes: on a rising edge with ld_en=1, busy=0 and ld_addr<DEPTH, entry ld_addr receives {ld_a, ld_b, ld_exp}. Writes with ld_addr>=DEPTH or busy=1 are dropped.
- Start acceptance: start is accepted only in IDLE or DONE. An accepted start clears err_cnt, fail_vld, fail_idx, done and pass, sets busy=1, and latches n=min(num_vec, DEPTH). start while busy is ignored.
- Simultaneous ld_en and start in the same cycle: the write commits. The first FETCH happens the next cycle and sees the new data.
- FSM states: IDLE, FETCH, WAIT, CHECK, DONE.
- IDLE/DONE -> accepted start: if n==0, go to DONE next cycle with pass=1. Otherwise set idx=0 and go to FETCH.
- FETCH: register add_a<=A[idx], add_b<=B[idx], exp_r<=EXP[idx]. Load wait counter with SETTLE. Go to WAIT, or straight to CHECK if SETTLE==0.
- WAIT: decrement the counter each cycle. Go to CHECK in the cycle after the counter reaches 0, so WAIT lasts exactly SETTLE cycles.
- CHECK: compare the full DW+1 bits of add_y against exp_r. On mismatch, err_cnt+1. If fail_vld==0, set fail_idx=idx and fail_vld=1.
  - If idx==n-1, go to DONE.
  - Else idx+1 and go to FETCH.
- DONE: busy=0, done=1, pass=(err_cnt==0). Remain until start or rst.
- Timing: each vector takes exactly 2+SETTLE cycles. Start-to-done takes n*(2+SETTLE)+1 cycles, with done visible on the following edge.
- add_a and add_b hold their last driven value outside FETCH, including in DONE.
- err_cnt never exceeds n <= DEPTH, so no saturation logic is needed.
- Reset mid-run aborts immediately to the reset values. No partial results are retained.
- The adder is combinational. add_y is stable by CHECK for any SETTLE >= 0.

Test Plan:
- Load 25 vectors with entry i = {a=i, b=i, exp=2i}. Use num_vec=25, SETTLE=1, and a correct adder. Expect done after 76 cycles, pass=1, err_cnt=0, fail_vld=0.
- Same table, but corrupt exp at index 7 (=0x0F) and index 12 (=0x00). Expect err_cnt=2, fail_idx=7, fail_vld=1, pass=0.
- Carry check: entry 0 = {0xFF, 0xFF, 0x1FE} and entry 1 = {0x80, 0x80, 0x100}, num_vec=2. Expect pass=1. Re-run with exp=0x0FE for entry 0. Expect err_cnt=1, fail_idx=0.
- num_vec=0 -> done=1 and pass=1 one cycle after start, with add_a/add_b unchanged. num_vec=40 with DEPTH=32 -> exactly 32 CHECK cycles occur.
- Pulse start, and ld_en to entry 3, mid-run. Expect the run to be unaffected and entry 3 unchanged on a re-run. Pulse start with ld_en in the same cycle to entry 0. Expect the new entry 0 to be used.
- Assert rst at cycle 10 of a 25-vector run. Expect all outputs at reset values on the next edge and FSM in IDLE. A fresh start then completes with correct results.

Source files
------------

// File: rtl/adder_vector_sequencer.sv
// Table-driven self-checking sequencer for an 8-bit adder datapath.
// Steps through stored {A, B, expected} vectors and reports mismatch count, first failing index and a pass flag.
module adder_vector_sequencer #(
   parameter int DW     = 8,
   parameter int DEPTH  = 32,
   parameter int AW     = 5,
   parameter int SETTLE = 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          ld_en,
   input  logic [AW-1:0] ld_addr,
   input  logic [DW-1:0] ld_a,
   input  logic [DW-1:0] ld_b,
   input  logic [DW:0]   ld_exp,
   input  logic [AW:0]   num_vec,
   input  logic          start,
   output logic [DW-1:0] add_a,
   output logic [DW-1:0] add_b,
   input  logic [DW:0]   add_y,
   output logic          busy,
   output logic          done,
   output logic          pass,
   output logic [AW:0]   err_cnt,
   output logic [AW-1:0] fail_idx,
   output logic          fail_vld
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      FETCH = 3'd1,
      WAIT  = 3'd2,
      CHECK = 3'd3,
      DONE  = 3'd4
   } state_t;

   localparam int         EW       = 3 * DW + 1;
   localparam logic [AW:0] depth_c = (AW + 1)'(DEPTH);
   localparam logic [3:0]  settle_c = 4'(SETTLE);

   // Entry layout: {a, b, exp}
   logic [EW-1:0] mem_r [DEPTH];

   state_t        state_r, state_nxt_s;
   logic [AW-1:0] idx_r;
   logic [AW:0]   n_r;
   logic [3:0]    cnt_r;
   logic [DW:0]   exp_r;
   logic [DW-1:0] add_a_r, add_b_r;
   logic          busy_r, done_r, pass_r, fail_vld_r;
   logic [AW:0]   err_cnt_r;
   logic [AW-1:0] fail_idx_r;

   logic          start_acc_s, wr_s, last_s, mismatch_s;
   logic [AW:0]   n_eff_s;
   logic          ld_ops_s, wait_s, chk_s, fin_s;

   assign start_acc_s = start && ((state_r == IDLE) || (state_r == DONE));
   assign n_eff_s     = (num_vec > depth_c) ? depth_c : num_vec;
   assign wr_s        = ld_en && !busy_r && ({1'b0, ld_addr} < depth_c);
   assign last_s      = ({1'b0, idx_r} == (n_r - {{AW{1'b0}}, 1'b1}));
   assign mismatch_s  = (add_y != exp_r);

   // Vector table write port; contents survive reset.
   always_ff @(posedge clk) begin
      if (wr_s) begin
         mem_r[ld_addr] <= {ld_a, ld_b, ld_exp};
      end
   end

   // FSM state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // FSM next-state logic.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         IDLE, DONE: begin
            if (start_acc_s) begin
               state_nxt_s = (n_eff_s == {(AW + 1){1'b0}}) ? DONE : FETCH;
            end else begin
               state_nxt_s = state_r;
            end
         end
         FETCH: begin
            state_nxt_s = (settle_c == 4'd0) ? CHECK : WAIT;
         end
         WAIT: begin
            if (cnt_r <= 4'd1) begin
               state_nxt_s = CHECK;
            end else begin
               state_nxt_s = WAIT;
            end
         end
         CHECK: begin
            state_nxt_s = last_s ? DONE : FETCH;
         end
         default: begin
            state_nxt_s = IDLE;
         end
      endcase
   end

   // FSM output decode into datapath strobes.
   always_comb begin
      ld_ops_s = 1'b0;
      wait_s   = 1'b0;
      chk_s    = 1'b0;
      fin_s    = 1'b0;
      case (state_r)
         FETCH:   ld_ops_s = 1'b1;
         WAIT:    wait_s   = 1'b1;
         CHECK:   chk_s    = 1'b1;
         DONE:    fin_s    = 1'b1;
         default: ld_ops_s = 1'b0;
      endcase
   end

   // Datapath and registered status outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         add_a_r    <= {DW{1'b0}};
         add_b_r    <= {DW{1'b0}};
         exp_r      <= {(DW + 1){1'b0}};
         idx_r      <= {AW{1'b0}};
         n_r        <= {(AW + 1){1'b0}};
         cnt_r      <= 4'd0;
         busy_r     <= 1'b0;
         done_r     <= 1'b0;
         pass_r     <= 1'b0;
         err_cnt_r  <= {(AW + 1){1'b0}};
         fail_idx_r <= {AW{1'b0}};
         fail_vld_r <= 1'b0;
      end else begin
         if (start_acc_s) begin
            busy_r     <= 1'b1;
            done_r     <= 1'b0;
            pass_r     <= 1'b0;
            err_cnt_r  <= {(AW + 1){1'b0}};
            fail_idx_r <= {AW{1'b0}};
            fail_vld_r <= 1'b0;
            n_r        <= n_eff_s;
            idx_r      <= {AW{1'b0}};
         end else if (fin_s) begin
            busy_r <= 1'b0;
            done_r <= 1'b1;
            pass_r <= (err_cnt_r == {(AW + 1){1'b0}});
         end
         if (ld_ops_s) begin
            add_a_r <= mem_r[idx_r][EW-1 -: DW];
            add_b_r <= mem_r[idx_r][2*DW -: DW];
            exp_r   <= mem_r[idx_r][DW:0];
            cnt_r   <= settle_c;
         end
         if (wait_s) begin
            cnt_r <= cnt_r - 4'd1;
         end
         if (chk_s) begin
            if (mismatch_s) begin
               err_cnt_r <= err_cnt_r + {{AW{1'b0}}, 1'b1};
               if (!fail_vld_r) begin
                  fail_idx_r <= idx_r;
                  fail_vld_r <= 1'b1;
               end
            end
            if (!last_s) begin
               idx_r <= idx_r + {{(AW - 1){1'b0}}, 1'b1};
            end
         end
      end
   end

   assign add_a    = add_a_r;
   assign add_b    = add_b_r;
   assign busy     = busy_r;
   assign done     = done_r;
   assign pass     = pass_r;
   assign err_cnt  = err_cnt_r;
   assign fail_idx = fail_idx_r;
   assign fail_vld = fail_vld_r;

endmodule

// File: tb/tb_adder_vector_sequencer.sv
// Directed bench for adder_vector_sequencer: a table model predicts each run's results into a scoreboard queue,
// which is popped and compared when the sequencer reports done.
module tb_adder_vector_sequencer;

   localparam int DW = 8, DEPTH = 32, AW = 5, SETTLE = 1;

   logic          clk = 1'b0;
   logic          rst, ld_en, start;
   logic [AW-1:0] ld_addr;
   logic [DW-1:0] ld_a, ld_b;
   logic [DW:0]   ld_exp;
   logic [AW:0]   num_vec;
   logic [DW-1:0] add_a, add_b;
   logic [DW:0]   add_y;
   logic          busy, done, pass, fail_vld;
   logic [AW:0]   err_cnt;
   logic [AW-1:0] fail_idx;

   typedef struct {
      int err;
      int fidx;
      int fvld;
      int pass;
      int cyc;
   } res_t;

   res_t          sb_q[$];
   logic [DW-1:0] ma [DEPTH];
   logic [DW-1:0] mb [DEPTH];
   logic [DW:0]   me [DEPTH];
   int            n_checks = 0;
   int            n_fail   = 0;
   logic [DW-1:0] hold_a, hold_b;

   assign add_y = {1'b0, add_a} + {1'b0, add_b};

   always #5 clk = ~clk;

   adder_vector_sequencer #(.DW(DW), .DEPTH(DEPTH), .AW(AW), .SETTLE(SETTLE)) dut (
      .clk(clk), .rst(rst), .ld_en(ld_en), .ld_addr(ld_addr), .ld_a(ld_a), .ld_b(ld_b),
      .ld_exp(ld_exp), .num_vec(num_vec), .start(start), .add_a(add_a), .add_b(add_b),
      .add_y(add_y), .busy(busy), .done(done), .pass(pass), .err_cnt(err_cnt),
      .fail_idx(fail_idx), .fail_vld(fail_vld)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic load(input int i, input logic [DW-1:0] a, input logic [DW-1:0] b, input logic [DW:0] e);
      ld_en = 1'b1; ld_addr = AW'(i); ld_a = a; ld_b = b; ld_exp = e;
      ma[i] = a; mb[i] = b; me[i] = e;
      @(negedge clk);
      ld_en = 1'b0;
   endtask

   // Predict a run from the table model and push it to the scoreboard.
   task automatic predict(input int nv);
      res_t r;
      int   n;
      logic [DW:0] sum;
      n = (nv > DEPTH) ? DEPTH : nv;
      r.err = 0; r.fidx = 0; r.fvld = 0;
      for (int i = 0; i < n; i++) begin
         sum = {1'b0, ma[i]} + {1'b0, mb[i]};
         if (sum !== me[i]) begin
            if (r.fvld == 0) begin
               r.fidx = i;
               r.fvld = 1;
            end
            r.err++;
         end
      end
      r.pass = (r.err == 0) ? 1 : 0;
      r.cyc  = n * (2 + SETTLE) + 1;
      sb_q.push_back(r);
   endtask

   // Start a run (optionally with a same-cycle write to entry 0, or a mid-run disturbance) and score it.
   task automatic run(input string tag, input int nv, input bit wr0, input bit disturb,
                      input logic [DW-1:0] wa, input logic [DW-1:0] wb, input logic [DW:0] we);
      res_t r;
      int   cyc;
      if (wr0) begin
         ma[0] = wa; mb[0] = wb; me[0] = we;
         ld_en = 1'b1; ld_addr = '0; ld_a = wa; ld_b = wb; ld_exp = we;
      end
      predict(nv);
      num_vec = (AW + 1)'(nv);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0; ld_en = 1'b0;
      cyc = 0;
      while (!done && cyc < 2000) begin
         if (disturb && cyc == 10) begin
            start = 1'b1; ld_en = 1'b1; ld_addr = 5'd3; ld_a = 8'hAA; ld_b = 8'h55; ld_exp = 9'h000;
         end else begin
            start = 1'b0; ld_en = 1'b0;
         end
         @(negedge clk);
         cyc++;
      end
      start = 1'b0; ld_en = 1'b0;
      r = sb_q.pop_front();
      check({tag, ".cycles"}, 32'(cyc), 32'(r.cyc));
      check({tag, ".busy"}, 32'(busy), 32'd0);
      check({tag, ".err_cnt"}, 32'(err_cnt), 32'(r.err));
      check({tag, ".fail_vld"}, 32'(fail_vld), 32'(r.fvld));
      check({tag, ".fail_idx"}, 32'(fail_idx), 32'(r.fidx));
      check({tag, ".pass"}, 32'(pass), 32'(r.pass));
      @(negedge clk);
   endtask

   task automatic check_reset_state(input string tag);
      check({tag, ".add_a"}, 32'(add_a), 32'd0);
      check({tag, ".add_b"}, 32'(add_b), 32'd0);
      check({tag, ".busy"}, 32'(busy), 32'd0);
      check({tag, ".done"}, 32'(done), 32'd0);
      check({tag, ".pass"}, 32'(pass), 32'd0);
      check({tag, ".err_cnt"}, 32'(err_cnt), 32'd0);
      check({tag, ".fail_idx"}, 32'(fail_idx), 32'd0);
      check({tag, ".fail_vld"}, 32'(fail_vld), 32'd0);
   endtask

   initial begin
      rst = 1'b1; ld_en = 1'b0; start = 1'b0; ld_addr = '0; ld_a = '0; ld_b = '0;
      ld_exp = '0; num_vec = '0;
      repeat (3) @(negedge clk);
      check_reset_state("reset");
      rst = 1'b0;

      // Straight-through table, all correct.
      for (int i = 0; i < DEPTH; i++) load(i, 8'(i), 8'(i), 9'(2 * i));
      run("t1_pass", 25, 1'b0, 1'b0, '0, '0, '0);

      // Two corrupted expectations.
      load(7, 8'd7, 8'd7, 9'h00F);
      load(12, 8'd12, 8'd12, 9'h000);
      run("t2_errs", 25, 1'b0, 1'b0, '0, '0, '0);

      // Carry-out into the ninth result bit.
      load(0, 8'hFF, 8'hFF, 9'h1FE);
      load(1, 8'h80, 8'h80, 9'h100);
      run("t3_carry", 2, 1'b0, 1'b0, '0, '0, '0);
      load(0, 8'hFF, 8'hFF, 9'h0FE);
      run("t3_carry_bad", 2, 1'b0, 1'b0, '0, '0, '0);

      // Empty run leaves operands untouched.
      hold_a = add_a; hold_b = add_b;
      run("t4_zero", 0, 1'b0, 1'b0, '0, '0, '0);
      check("t4_zero.add_a", 32'(add_a), 32'(hold_a));
      check("t4_zero.add_b", 32'(add_b), 32'(hold_b));

      // Oversized request clamps to the table depth.
      run("t4_clamp", 40, 1'b0, 1'b0, '0, '0, '0);

      // Mid-run start and write are ignored; re-run shows entry 3 intact.
      run("t5_disturb", 25, 1'b0, 1'b1, '0, '0, '0);
      run("t5_rerun", 25, 1'b0, 1'b0, '0, '0, '0);

      // Write and start in the same cycle: new entry 0 is used.
      run("t5_same_cyc", 25, 1'b1, 1'b0, 8'h11, 8'h22, 9'h034);
      run("t5_same_cyc_ok", 25, 1'b1, 1'b0, 8'h11, 8'h22, 9'h033);

      // Reset mid-run aborts to reset values.
      num_vec = 6'd25;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (10) @(negedge clk);
      check("t6_midrun.busy", 32'(busy), 32'd1);
      rst = 1'b1;
      @(negedge clk);
      check_reset_state("t6_reset");
      rst = 1'b0;
      @(negedge clk);
      check("t6_idle.busy", 32'(busy), 32'd0);
      run("t6_fresh", 25, 1'b0, 1'b0, '0, '0, '0);

      check("scoreboard.empty", 32'(sb_q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
